// File: rtl/seg_to_num_decoder.sv
// Seven-segment to BCD decoder with stability filter for display loopback self-check.
// Optional macro SEG_DPT_CHECK_EN adds the decimal points to the compared pattern and flags lit points as bad.
module seg_to_num_decoder #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       seg1,
    input  logic [6:0]       seg2,
    input  logic [6:0]       seg3,
    input  logic             seg1_dpt,
    input  logic             seg2_dpt,
    input  logic             seg3_dpt,
    output logic [3:0]       dig1,
    output logic [3:0]       dig2,
    output logic [3:0]       dig3,
    output logic [2:0]       blank,
    output logic [2:0]       bad,
    output logic             out_valid,
    output logic [CNT_W-1:0] change_cnt
);

    // state  | meaning
    // IDLE   | input matches last committed pattern
    // SETTLE | candidate pattern seen, counting stable edges
    // COMMIT | one-cycle valid pulse, inputs ignored
    typedef enum logic [1:0] {IDLE, SETTLE, COMMIT} state_t;

    localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);

`ifdef SEG_DPT_CHECK_EN
    localparam int PW = 24;
    logic [PW-1:0] pat;
    assign pat = {seg1, seg1_dpt, seg2, seg2_dpt, seg3, seg3_dpt};
`else
    localparam int PW = 21;
    logic [PW-1:0] pat;
    logic          dpt_unused;
    assign pat        = {seg1, seg2, seg3};
    assign dpt_unused = ^{seg1_dpt, seg2_dpt, seg3_dpt};
`endif

    state_t        state;
    logic [PW-1:0] snapshot;
    logic [PW-1:0] cand;
    logic [7:0]    cnt;

    // {blank, bad, digit}
    function automatic logic [5:0] decode(input logic [6:0] s);
        case (s)
            7'b1000000: decode = {2'b00, 4'd0};
            7'b1111001: decode = {2'b00, 4'd1};
            7'b0100100: decode = {2'b00, 4'd2};
            7'b0110000: decode = {2'b00, 4'd3};
            7'b0011001: decode = {2'b00, 4'd4};
            7'b0010010: decode = {2'b00, 4'd5};
            7'b0000010: decode = {2'b00, 4'd6};
            7'b1111000: decode = {2'b00, 4'd7};
            7'b0000000: decode = {2'b00, 4'd8};
            7'b0010000: decode = {2'b00, 4'd9};
            7'b1111111: decode = {2'b10, 4'hF};
            default:    decode = {2'b01, 4'hE};
        endcase
    endfunction

    logic [5:0] dec1, dec2, dec3;

`ifdef SEG_DPT_CHECK_EN
    // A lit decimal point overrides whatever the segments show.
    assign dec1 = cand[16] ? decode(cand[23:17]) : {2'b01, 4'hE};
    assign dec2 = cand[8]  ? decode(cand[15:9])  : {2'b01, 4'hE};
    assign dec3 = cand[0]  ? decode(cand[7:1])   : {2'b01, 4'hE};
`else
    assign dec1 = decode(cand[20:14]);
    assign dec2 = decode(cand[13:7]);
    assign dec3 = decode(cand[6:0]);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            dig1       <= 4'hF;
            dig2       <= 4'hF;
            dig3       <= 4'hF;
            blank      <= 3'b111;
            bad        <= 3'b000;
            out_valid  <= 1'b0;
            change_cnt <= '0;
            snapshot   <= '1;
            cand       <= '1;
            cnt        <= 8'd0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (pat != snapshot) begin
                        cand  <= pat;
                        cnt   <= 8'd1;
                        state <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (pat == snapshot) begin
                        state <= IDLE;
                    end else if (pat != cand) begin
                        cand <= pat;
                        cnt  <= 8'd1;
                    end else if (cnt == CNT_LAST) begin
                        state     <= COMMIT;
                        out_valid <= 1'b1;
                        snapshot  <= cand;
                        dig1      <= dec1[3:0];
                        dig2      <= dec2[3:0];
                        dig3      <= dec3[3:0];
                        blank     <= {dec3[5], dec2[5], dec1[5]};
                        bad       <= {dec3[4], dec2[4], dec1[4]};
                        if (change_cnt != {CNT_W{1'b1}})
                            change_cnt <= change_cnt + 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                COMMIT:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seg_to_num_decoder.sv
// Scoreboard bench for seg_to_num_decoder: directed display scenarios plus random pattern streams.
// Honours SEG_DPT_CHECK_EN the same way the design does.
module tb_seg_to_num_decoder;

    localparam int STABLE = 4;
    localparam int CW     = 2;
    localparam int OW     = 18 + CW;
    localparam logic [OW-1:0] RST_VAL = {12'hFFF, 3'b111, 3'b000, {CW{1'b0}}};

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [6:0]    seg1 = '1, seg2 = '1, seg3 = '1;
    logic          seg1_dpt = 1'b1, seg2_dpt = 1'b1, seg3_dpt = 1'b1;
    logic [3:0]    dig1, dig2, dig3;
    logic [2:0]    blank, bad;
    logic          out_valid;
    logic [CW-1:0] change_cnt;

    seg_to_num_decoder #(.STABLE_CYCLES(STABLE), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .seg1(seg1), .seg2(seg2), .seg3(seg3),
        .seg1_dpt(seg1_dpt), .seg2_dpt(seg2_dpt), .seg3_dpt(seg3_dpt),
        .dig1(dig1), .dig2(dig2), .dig3(dig3),
        .blank(blank), .bad(bad), .out_valid(out_valid), .change_cnt(change_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        int            cyc;
        logic [OW-1:0] val;
    } exp_t;
    exp_t q[$];

    logic [OW-1:0] obs;
    assign obs = {dig1, dig2, dig3, blank, bad, change_cnt};

    // ---------------- reference model ----------------
    logic [6:0] digit_tbl [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                   7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    logic [26:0] m_snap, m_last;
    int          m_run, m_cnt;
    bit          m_block;

    function automatic logic [26:0] snap_reset();
`ifdef SEG_DPT_CHECK_EN
        return {3'b0, 24'hFFFFFF};
`else
        return {6'b0, 21'h1FFFFF};
`endif
    endfunction

    function automatic logic [26:0] mk_pat(logic [6:0] a, logic [6:0] b, logic [6:0] c,
                                           logic da, logic db, logic dc);
`ifdef SEG_DPT_CHECK_EN
        return {3'b0, a, da, b, db, c, dc};
`else
        return {6'b0, a, b, c};
`endif
    endfunction

    // returns {blank, bad, digit}
    function automatic logic [5:0] ref_decode(logic [6:0] s, logic dp);
        logic [5:0] r;
        r = {2'b01, 4'hE};
        if (s == 7'h7F) r = {2'b10, 4'hF};
        for (int d = 0; d < 10; d++)
            if (s == digit_tbl[d]) r = {2'b00, 4'(d)};
`ifdef SEG_DPT_CHECK_EN
        if (dp == 1'b0) r = {2'b01, 4'hE};
`endif
        return r;
    endfunction

    task automatic model_reset();
        m_snap  = snap_reset();
        m_last  = '0;
        m_run   = 0;
        m_cnt   = 0;
        m_block = 0;
    endtask

    // One sampling edge: commit once the same non-snapshot pattern has been seen STABLE times in a row.
    task automatic model_sample();
        logic [26:0] p;
        logic [5:0]  r1, r2, r3;
        exp_t        e;
        p = mk_pat(seg1, seg2, seg3, seg1_dpt, seg2_dpt, seg3_dpt);
        if (m_block) begin
            m_block = 0;
            m_run   = 0;
        end else if (p == m_snap) begin
            m_run = 0;
        end else begin
            if (m_run > 0 && p == m_last) m_run++;
            else begin
                m_run  = 1;
                m_last = p;
            end
            if (m_run == STABLE) begin
                m_snap = p;
                if (m_cnt < (1 << CW) - 1) m_cnt++;
                r1 = ref_decode(seg1, seg1_dpt);
                r2 = ref_decode(seg2, seg2_dpt);
                r3 = ref_decode(seg3, seg3_dpt);
                e.cyc = cyc + 1;
                e.val = {r1[3:0], r2[3:0], r3[3:0], r3[5], r2[5], r1[5], r3[4], r2[4], r1[4], CW'(m_cnt)};
                q.push_back(e);
                m_block = 1;
                m_run   = 0;
            end
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic drive(logic [6:0] a, logic [6:0] b, logic [6:0] c,
                         logic da, logic db, logic dc, int n);
        for (int i = 0; i < n; i++) begin
            seg1 = a; seg2 = b; seg3 = c;
            seg1_dpt = da; seg2_dpt = db; seg3_dpt = dc;
            model_sample();
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        n_chk++;
        if (obs !== RST_VAL || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got %h valid=%b, want %h valid=0", obs, out_valid, RST_VAL);
        end
        q.delete();
        model_reset();
        @(posedge clk);
        #2 rst = 1'b0;
    endtask

    function automatic logic [6:0] rand_seg();
        int k;
        k = $urandom_range(0, 11);
        if (k < 10) return digit_tbl[k];
        if (k == 10) return 7'h7F;
        return 7'($urandom);
    endfunction

    // ---------------- monitor ----------------
    initial begin
        logic [OW-1:0] last;
        exp_t          e;
        last = RST_VAL;
        forever begin
            @(negedge clk);
            if (rst) begin
                last = RST_VAL;
            end else if (q.size() > 0 && q[0].cyc == cyc) begin
                e = q.pop_front();
                n_chk++;
                if (out_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL pulse_missing cyc=%0d: out_valid=%b, want 1", cyc, out_valid);
                end
                n_chk++;
                if (obs !== e.val) begin
                    n_fail++;
                    $display("FAIL commit_value cyc=%0d: got %h, want %h", cyc, obs, e.val);
                end
                last = e.val;
            end else begin
                n_chk++;
                if (out_valid !== 1'b0 || obs !== last) begin
                    n_fail++;
                    $display("FAIL hold cyc=%0d: got %h valid=%b, want %h valid=0", cyc, obs, out_valid, last);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [6:0] ra, rb, rc;
        logic [6:0] ha, hb, hc;
        logic       da, db, dc;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        drive(7'b1111001, 7'b0100100, 7'b0110000, 1, 1, 1, 10);   // nominal 1/2/3
        drive(7'b0010010, 7'b0100100, 7'b0110000, 1, 1, 1, 2);    // glitch
        drive(7'b1111001, 7'b0100100, 7'b0110000, 1, 1, 1, 6);
        drive(7'b0000000, 7'b0000000, 7'b0000000, 1, 1, 1, 3);    // restart A -> B
        drive(7'b0010000, 7'b1000000, 7'b1000000, 1, 1, 1, 8);
        drive(7'b1111111, 7'b1000000, 7'b1010101, 1, 1, 1, 8);    // blank / invalid
        drive(7'b1111111, 7'b1000000, 7'b1010101, 1, 0, 1, 8);    // dpt-only change
        drive(7'b0011001, 7'b0000010, 7'b1111000, 1, 1, 1, 4);    // exact-length commit
        drive(7'b0000000, 7'b0000010, 7'b1111000, 1, 1, 1, 3);    // change lands in COMMIT
        drive(7'b0000000, 7'b0000010, 7'b1111000, 1, 1, 1, 6);

        drive(7'b0010010, 7'b0010010, 7'b0010010, 1, 1, 1, 2);    // abort mid-SETTLE by reset
        do_reset();
        drive(7'b0010010, 7'b0010010, 7'b0010010, 1, 1, 1, 6);

        ha = seg1; hb = seg2; hc = seg3;
        for (int s = 0; s < 400; s++) begin
            if ($urandom_range(0, 4) == 0) begin
                ra = ha; rb = hb; rc = hc;
            end else begin
                ra = rand_seg(); rb = rand_seg(); rc = rand_seg();
                if ($urandom_range(0, 1) == 0) begin
                    rb = hb; rc = hc;
                end
            end
            da = ($urandom_range(0, 7) != 0);
            db = ($urandom_range(0, 7) != 0);
            dc = ($urandom_range(0, 7) != 0);
            drive(ra, rb, rc, da, db, dc, $urandom_range(1, 6));
            if ($urandom_range(0, 2) == 0) begin
                ha = ra; hb = rb; hc = rc;
            end
        end

        drive(seg1, seg2, seg3, seg1_dpt, seg2_dpt, seg3_dpt, 8);
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected commits not seen, want 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
